// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C target: widths and FSM state encoding.
package i2c_pkg;

    localparam int I2C_ADDR_W = 7;
    localparam int I2C_BYTE_W = 8;

    localparam logic [2:0] ENC_IDLE     = 3'd0;
    localparam logic [2:0] ENC_ADDR     = 3'd1;
    localparam logic [2:0] ENC_ADDR_ACK = 3'd2;
    localparam logic [2:0] ENC_WR_DATA  = 3'd3;
    localparam logic [2:0] ENC_WR_ACK   = 3'd4;
    localparam logic [2:0] ENC_RD_DATA  = 3'd5;
    localparam logic [2:0] ENC_RD_ACK   = 3'd6;
    localparam logic [2:0] ENC_SKIP     = 3'd7;

    typedef enum logic [2:0] {
        ST_IDLE     = ENC_IDLE,
        ST_ADDR     = ENC_ADDR,
        ST_ADDR_ACK = ENC_ADDR_ACK,
        ST_WR_DATA  = ENC_WR_DATA,
        ST_WR_ACK   = ENC_WR_ACK,
        ST_RD_DATA  = ENC_RD_DATA,
        ST_RD_ACK   = ENC_RD_ACK,
        ST_SKIP     = ENC_SKIP
    } i2c_state_e;

endpackage

// File: rtl/i2c_line_sync.sv
// SCL/SDA synchronizers with registered edge, START and STOP events.
module i2c_line_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic scl_in,
    input  logic sda_in,
    output logic scl,
    output logic sda,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det
);

    logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d;
    logic [SYNC_STAGES-1:0] sda_sync_q, sda_sync_d;
    logic scl_dly_q, scl_dly_d;
    logic sda_dly_q, sda_dly_d;
    logic rise_q, rise_d;
    logic fall_q, fall_d;
    logic start_q, start_d;
    logic stop_q, stop_d;
    logic scl_s, sda_s;

    assign scl_s = scl_sync_q[SYNC_STAGES-1];
    assign sda_s = sda_sync_q[SYNC_STAGES-1];

    always_comb begin
        scl_sync_d = {scl_sync_q[SYNC_STAGES-2:0], scl_in};
        sda_sync_d = {sda_sync_q[SYNC_STAGES-2:0], sda_in};
        scl_dly_d  = scl_s;
        sda_dly_d  = sda_s;
        rise_d     = scl_s & ~scl_dly_q;
        fall_d     = ~scl_s & scl_dly_q;
        start_d    = scl_s & sda_dly_q & ~sda_s;
        stop_d     = scl_s & ~sda_dly_q & sda_s;
    end

    // Idle bus is high on both lines, so reset to 1 to avoid false edges.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_dly_q  <= 1'b1;
            sda_dly_q  <= 1'b1;
            rise_q     <= 1'b0;
            fall_q     <= 1'b0;
            start_q    <= 1'b0;
            stop_q     <= 1'b0;
        end else begin
            scl_sync_q <= scl_sync_d;
            sda_sync_q <= sda_sync_d;
            scl_dly_q  <= scl_dly_d;
            sda_dly_q  <= sda_dly_d;
            rise_q     <= rise_d;
            fall_q     <= fall_d;
            start_q    <= start_d;
            stop_q     <= stop_d;
        end
    end

    // Levels are the delayed copies so they line up with the events.
    assign scl       = scl_dly_q;
    assign sda       = sda_dly_q;
    assign scl_rise  = rise_q;
    assign scl_fall  = fall_q;
    assign start_det = start_q;
    assign stop_det  = stop_q;

endmodule

// File: rtl/i2c_slave.sv
// I2C target: fixed address, byte writes to local logic, byte reads from it.
module i2c_slave
    import i2c_pkg::*;
#(
    parameter logic [I2C_ADDR_W-1:0] SLAVE_ADDR  = 7'h2A,
    parameter int                    SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  SCL,
    inout  wire                   SDA,
    input  logic [I2C_BYTE_W-1:0] tx_data,
    output logic                  tx_req,
    output logic [I2C_BYTE_W-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  rw,
    output logic                  busy
);

    logic scl_lvl, sda_lvl, scl_rise, scl_fall, start_det, stop_det;
    logic fall_ev;

    i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk       (clk),
        .reset_n   (reset_n),
        .scl_in    (SCL),
        .sda_in    (SDA),
        .scl       (scl_lvl),
        .sda       (sda_lvl),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall),
        .start_det (start_det),
        .stop_det  (stop_det)
    );

    i2c_state_e state_q, state_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [I2C_BYTE_W-1:0] shift_q, shift_d, shift_in;
    logic [I2C_BYTE_W-1:0] rx_data_q, rx_data_d;
    logic ack_ph_q, ack_ph_d;
    logic sda_low_q, sda_low_d;
    logic rx_valid_q, rx_valid_d;
    logic tx_req_q, tx_req_d;
    logic rw_q, rw_d;
    logic busy_q, busy_d;

    assign shift_in = {shift_q[I2C_BYTE_W-2:0], sda_lvl};
    // SDA drive only ever moves while SCL is known low.
    assign fall_ev  = scl_fall & ~scl_lvl;

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        rx_data_d  = rx_data_q;
        ack_ph_d   = ack_ph_q;
        sda_low_d  = sda_low_q;
        rw_d       = rw_q;
        busy_d     = busy_q;
        rx_valid_d = 1'b0;
        tx_req_d   = 1'b0;
        if (stop_det) begin
            state_d   = ST_IDLE;
            sda_low_d = 1'b0;
            busy_d    = 1'b0;
            ack_ph_d  = 1'b0;
        end else if (start_det) begin
            state_d   = ST_ADDR;
            bit_cnt_d = '0;
            sda_low_d = 1'b0;
            busy_d    = 1'b1;
            ack_ph_d  = 1'b0;
        end else begin
            unique case (state_q)
                ST_ADDR: if (scl_rise) begin
                    shift_d   = shift_in;
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        if (shift_in[7:1] == SLAVE_ADDR) begin
                            state_d  = ST_ADDR_ACK;
                            rw_d     = shift_in[0];
                            tx_req_d = shift_in[0];
                            ack_ph_d = 1'b0;
                        end else begin
                            state_d = ST_SKIP;
                        end
                    end
                end
                ST_ADDR_ACK: if (fall_ev) begin
                    if (!ack_ph_q) begin
                        sda_low_d = 1'b1;
                        ack_ph_d  = 1'b1;
                    end else begin
                        ack_ph_d  = 1'b0;
                        bit_cnt_d = '0;
                        if (rw_q) begin
                            state_d   = ST_RD_DATA;
                            shift_d   = tx_data;
                            sda_low_d = ~tx_data[7];
                        end else begin
                            state_d   = ST_WR_DATA;
                            sda_low_d = 1'b0;
                        end
                    end
                end
                ST_WR_DATA: if (scl_rise) begin
                    shift_d   = shift_in;
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        rx_data_d  = shift_in;
                        rx_valid_d = 1'b1;
                        state_d    = ST_WR_ACK;
                        ack_ph_d   = 1'b0;
                    end
                end
                ST_WR_ACK: if (fall_ev) begin
                    if (!ack_ph_q) begin
                        sda_low_d = 1'b1;
                        ack_ph_d  = 1'b1;
                    end else begin
                        sda_low_d = 1'b0;
                        ack_ph_d  = 1'b0;
                        bit_cnt_d = '0;
                        state_d   = ST_WR_DATA;
                    end
                end
                ST_RD_DATA: if (fall_ev) begin
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        sda_low_d = 1'b0;
                        ack_ph_d  = 1'b0;
                        state_d   = ST_RD_ACK;
                    end else begin
                        shift_d   = {shift_q[6:0], shift_q[7]};
                        sda_low_d = ~shift_q[6];
                    end
                end
                ST_RD_ACK: begin
                    if (scl_rise && !ack_ph_q) begin
                        if (!sda_lvl) begin
                            tx_req_d = 1'b1;
                            ack_ph_d = 1'b1;
                        end else begin
                            state_d = ST_SKIP;
                        end
                    end else if (fall_ev && ack_ph_q) begin
                        ack_ph_d  = 1'b0;
                        bit_cnt_d = '0;
                        shift_d   = tx_data;
                        sda_low_d = ~tx_data[7];
                        state_d   = ST_RD_DATA;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            rx_data_q  <= '0;
            ack_ph_q   <= 1'b0;
            sda_low_q  <= 1'b0;
            rx_valid_q <= 1'b0;
            tx_req_q   <= 1'b0;
            rw_q       <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            rx_data_q  <= rx_data_d;
            ack_ph_q   <= ack_ph_d;
            sda_low_q  <= sda_low_d;
            rx_valid_q <= rx_valid_d;
            tx_req_q   <= tx_req_d;
            rw_q       <= rw_d;
            busy_q     <= busy_d;
        end
    end

    assign SDA      = sda_low_q ? 1'b0 : 1'bz;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign tx_req   = tx_req_q;
    assign rw       = rw_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_i2c_slave.sv
// Bus-master bench for i2c_slave: vector table, corner sequences, random transfers.
module tb_i2c_slave;

    localparam int Q = 4;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic scl = 1'b1;
    logic m_low = 1'b0;
    logic [7:0] tx_data = 8'h00;
    wire sda_bus;
    logic tx_req, rx_valid, rw, busy;
    logic [7:0] rx_data;

    pullup (sda_bus);
    assign sda_bus = m_low ? 1'b0 : 1'bz;

    i2c_slave #(.SLAVE_ADDR(7'h2A), .SYNC_STAGES(2)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .SCL      (scl),
        .SDA      (sda_bus),
        .tx_data  (tx_data),
        .tx_req   (tx_req),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rw       (rw),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    int total = 0, bad = 0;
    int rxv_cnt = 0, txr_cnt = 0, dut_low_cnt = 0, busy_fall_cnt = 0;
    logic busy_prev = 1'b0;
    logic [7:0] tx_feed[$], tx_sent[$], wr_q[$], rd_got[$];
    bit addr_ack, data_ack_all, nack_rel;

    // Local-logic side: answer each tx_req with the next byte.
    always @(negedge clk) begin
        #1;
        if (rx_valid) rxv_cnt++;
        if (tx_req) begin
            if (tx_feed.size() > 0) tx_data = tx_feed.pop_front();
            else tx_data = 8'($urandom);
            tx_sent.push_back(tx_data);
            txr_cnt++;
        end
        if (sda_bus === 1'b0 && !m_low) dut_low_cnt++;
        if (busy_prev && !busy) busy_fall_cnt++;
        busy_prev = busy;
    end

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input bit b, output bit s);
        m_low = !b;
        wait_clk(Q);
        scl = 1'b1;
        wait_clk(Q);
        s = (sda_bus === 1'b1);
        wait_clk(Q);
        scl = 1'b0;
        wait_clk(Q);
    endtask

    task automatic m_start();
        m_low = 1'b0;
        wait_clk(Q);
        scl = 1'b1;
        wait_clk(Q);
        m_low = 1'b1;
        wait_clk(Q);
        scl = 1'b0;
        wait_clk(Q);
    endtask

    task automatic m_stop();
        m_low = 1'b1;
        wait_clk(Q);
        scl = 1'b1;
        wait_clk(Q);
        m_low = 1'b0;
        wait_clk(2 * Q);
    endtask

    task automatic wr_byte(input logic [7:0] b, output bit ack);
        bit s;
        for (int i = 7; i >= 0; i--) send_bit(b[i], s);
        send_bit(1'b1, s);
        ack = !s;
    endtask

    task automatic rd_byte(input bit ack_it, output logic [7:0] b);
        bit s;
        b = 8'h00;
        for (int i = 0; i < 8; i++) begin
            send_bit(1'b1, s);
            b = {b[6:0], s};
        end
        send_bit(!ack_it, s);
    endtask

    task automatic xfer(input logic [7:0] ab, input int n, input bit do_stop);
        bit a;
        logic [7:0] b;
        rd_got.delete();
        data_ack_all = 1'b1;
        nack_rel = 1'b0;
        m_start();
        wr_byte(ab, a);
        addr_ack = a;
        if (ab[0] && a) begin
            for (int i = 0; i < n; i++) begin
                rd_byte(i < n - 1, b);
                rd_got.push_back(b);
            end
            nack_rel = (sda_bus === 1'b1);
        end else begin
            for (int i = 0; i < n; i++) begin
                b = (wr_q.size() > 0) ? wr_q.pop_front() : 8'hFF;
                wr_byte(b, a);
                data_ack_all = data_ack_all & a;
            end
        end
        if (do_stop) m_stop();
    endtask

    typedef struct {
        logic [7:0] ab;
        int         n;
        logic [7:0] d0, d1;
        bit         exp_ack;
        int         exp_rxv;
        int         exp_txr;
        logic [7:0] exp_rx;
        bit         exp_rw;
    } vec_t;

    vec_t vecs[4];

    initial begin
        int rxv0, txr0, low0, bf0;
        bit a, s, quiet;
        logic [7:0] m_rx, last_wr;
        bit m_rw;

        vecs[0] = '{8'h54, 1, 8'hA5, 8'h00, 1'b1, 1, 0, 8'hA5, 1'b0};
        vecs[1] = '{8'h56, 1, 8'hFF, 8'h00, 1'b0, 0, 0, 8'hA5, 1'b0};
        vecs[2] = '{8'h55, 2, 8'h3C, 8'hC3, 1'b1, 0, 2, 8'hA5, 1'b1};
        vecs[3] = '{8'h54, 2, 8'h11, 8'h7E, 1'b1, 2, 0, 8'h7E, 1'b0};

        wait_clk(5);
        check("rst_rx_data", rx_data, 8'h00);
        check("rst_rx_valid", rx_valid, 1'b0);
        check("rst_tx_req", tx_req, 1'b0);
        check("rst_rw", rw, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_sda", sda_bus, 1'b1);
        reset_n = 1'b1;
        wait_clk(5);

        for (int v = 0; v < 4; v++) begin
            rxv0 = rxv_cnt; txr0 = txr_cnt; low0 = dut_low_cnt;
            wr_q = '{vecs[v].d0, vecs[v].d1};
            tx_feed = '{vecs[v].d0, vecs[v].d1};
            tx_sent.delete();
            xfer(vecs[v].ab, vecs[v].n, 1'b1);
            check($sformatf("v%0d_addr_ack", v), addr_ack, vecs[v].exp_ack);
            if (vecs[v].ab[0] && vecs[v].exp_ack) begin
                check($sformatf("v%0d_rd_cnt", v), rd_got.size(), vecs[v].n);
                if (rd_got.size() > 0)
                    check($sformatf("v%0d_rd0", v), rd_got[0], vecs[v].d0);
                if (rd_got.size() > 1)
                    check($sformatf("v%0d_rd1", v), rd_got[1], vecs[v].d1);
                check($sformatf("v%0d_nack_rel", v), nack_rel, 1'b1);
            end else begin
                check($sformatf("v%0d_data_ack", v), data_ack_all, vecs[v].exp_ack);
            end
            if (!vecs[v].exp_ack)
                check($sformatf("v%0d_never_low", v), dut_low_cnt - low0, 0);
            check($sformatf("v%0d_rxv", v), rxv_cnt - rxv0, vecs[v].exp_rxv);
            check($sformatf("v%0d_txr", v), txr_cnt - txr0, vecs[v].exp_txr);
            check($sformatf("v%0d_rx_data", v), rx_data, vecs[v].exp_rx);
            check($sformatf("v%0d_rw", v), rw, vecs[v].exp_rw);
            check($sformatf("v%0d_busy", v), busy, 1'b0);
        end

        // Repeated start: write then read without an intervening STOP.
        bf0 = busy_fall_cnt;
        wr_q = '{8'h11};
        xfer(8'h54, 1, 1'b0);
        check("rs_wr_ack", data_ack_all, 1'b1);
        check("rs_rx_data", rx_data, 8'h11);
        check("rs_rw0", rw, 1'b0);
        tx_feed = '{8'h99};
        tx_sent.delete();
        xfer(8'h55, 1, 1'b0);
        check("rs_addr_ack", addr_ack, 1'b1);
        check("rs_rw1", rw, 1'b1);
        check("rs_rd", rd_got.size() > 0 ? rd_got[0] : 8'hxx, 8'h99);
        check("rs_busy_held", busy_fall_cnt - bf0, 0);
        check("rs_busy_hi", busy, 1'b1);
        m_stop();
        check("rs_busy_lo", busy, 1'b0);

        // STOP arrives together with the 8th SCL rise of a write byte.
        rxv0 = rxv_cnt;
        m_start();
        wr_byte(8'h54, a);
        check("ss_addr_ack", a, 1'b1);
        for (int i = 0; i < 7; i++) send_bit(1'b1, s);
        m_low = 1'b1;
        wait_clk(Q);
        scl = 1'b1;
        m_low = 1'b0;
        wait_clk(2 * Q);
        check("ss_no_rxv", rxv_cnt - rxv0, 0);
        check("ss_busy", busy, 1'b0);
        check("ss_rx_data", rx_data, 8'h11);

        // Reset while the target is driving bit 3 of a read byte.
        tx_feed = '{8'h00};
        m_start();
        wr_byte(8'h55, a);
        check("rr_addr_ack", a, 1'b1);
        for (int i = 0; i < 4; i++) send_bit(1'b1, s);
        m_low = 1'b0;
        wait_clk(Q);
        scl = 1'b1;
        wait_clk(Q);
        check("rr_driving", sda_bus, 1'b0);
        reset_n = 1'b0;
        wait_clk(1);
        check("rr_sda_rel", sda_bus, 1'b1);
        check("rr_rx_data", rx_data, 8'h00);
        check("rr_rx_valid", rx_valid, 1'b0);
        check("rr_tx_req", tx_req, 1'b0);
        check("rr_rw", rw, 1'b0);
        check("rr_busy", busy, 1'b0);
        reset_n = 1'b1;
        wait_clk(Q);
        scl = 1'b0;
        wait_clk(Q);
        quiet = 1'b1;
        for (int i = 0; i < 6; i++) begin
            send_bit(1'b1, s);
            quiet = quiet & s;
        end
        check("rr_quiet", quiet, 1'b1);
        check("rr_busy_quiet", busy, 1'b0);
        rxv0 = rxv_cnt;
        wr_q = '{8'h5A};
        xfer(8'h54, 1, 1'b1);
        check("rr_after_ack", addr_ack & data_ack_all, 1'b1);
        check("rr_after_rx", rx_data, 8'h5A);
        check("rr_after_rxv", rxv_cnt - rxv0, 1);

        // Random transfers against a transaction-level model.
        m_rx = 8'h5A;
        m_rw = 1'b0;
        for (int k = 0; k < 20; k++) begin
            bit match, rd;
            int n;
            logic [6:0] a7;
            match = 1'($urandom_range(0, 1));
            rd = 1'($urandom_range(0, 1));
            n = $urandom_range(1, 3);
            a7 = 7'h2A;
            if (!match) begin
                do a7 = 7'($urandom); while (a7 == 7'h2A);
            end
            wr_q.delete();
            last_wr = 8'h00;
            for (int i = 0; i < n; i++) begin
                last_wr = 8'($urandom);
                wr_q.push_back(last_wr);
            end
            tx_feed.delete();
            tx_sent.delete();
            rxv0 = rxv_cnt; txr0 = txr_cnt; low0 = dut_low_cnt;
            if (match && !rd) m_rx = last_wr;
            if (match) m_rw = rd;
            xfer({a7, rd}, n, 1'b1);
            check($sformatf("r%0d_addr_ack", k), addr_ack, match);
            check($sformatf("r%0d_rxv", k), rxv_cnt - rxv0, (match && !rd) ? n : 0);
            check($sformatf("r%0d_txr", k), txr_cnt - txr0, (match && rd) ? n : 0);
            check($sformatf("r%0d_rx_data", k), rx_data, m_rx);
            check($sformatf("r%0d_rw", k), rw, m_rw);
            check($sformatf("r%0d_busy", k), busy, 1'b0);
            if (match && rd) begin
                check($sformatf("r%0d_rd_cnt", k), rd_got.size(), n);
                for (int i = 0; i < rd_got.size() && i < tx_sent.size(); i++)
                    check($sformatf("r%0d_rd%0d", k, i), rd_got[i], tx_sent[i]);
                check($sformatf("r%0d_nack_rel", k), nack_rel, 1'b1);
            end else begin
                check($sformatf("r%0d_data_ack", k), data_ack_all, match);
            end
            if (!match)
                check($sformatf("r%0d_never_low", k), dut_low_cnt - low0, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
